// File: rtl/ds2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ds2_pkg
// Description : Shared DualShock2 protocol constants, state encoding and
//               button bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package ds2_pkg;

    localparam logic [7:0] c_id_digital   = 8'h41;
    localparam logic [7:0] c_id_analog    = 8'h73;
    localparam logic [7:0] c_id_config    = 8'hF3;
    localparam logic [7:0] c_hdr_5a       = 8'h5A;
    localparam logic [7:0] c_reply_idle   = 8'hFF;

    localparam logic [7:0] c_cmd_start    = 8'h01;
    localparam logic [7:0] c_cmd_poll     = 8'h42;
    localparam logic [7:0] c_cmd_config   = 8'h43;
    localparam logic [7:0] c_cmd_set_mode = 8'h44;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_IGNORE  = 2'd3
    } ds2_state_e;

    localparam int unsigned c_btn_select   = 0;
    localparam int unsigned c_btn_l3       = 1;
    localparam int unsigned c_btn_r3       = 2;
    localparam int unsigned c_btn_start    = 3;
    localparam int unsigned c_btn_up       = 4;
    localparam int unsigned c_btn_right    = 5;
    localparam int unsigned c_btn_down     = 6;
    localparam int unsigned c_btn_left     = 7;
    localparam int unsigned c_btn_l2       = 8;
    localparam int unsigned c_btn_r2       = 9;
    localparam int unsigned c_btn_l1       = 10;
    localparam int unsigned c_btn_r1       = 11;
    localparam int unsigned c_btn_triangle = 12;
    localparam int unsigned c_btn_circle   = 13;
    localparam int unsigned c_btn_cross    = 14;
    localparam int unsigned c_btn_square   = 15;

endpackage
`default_nettype wire

// File: rtl/ds2_input_sync.sv
`default_nettype none
// ============================================================================
// Module      : ds2_input_sync
// Description : Two-flop synchronizer with rise/fall pulses for one pad line.
// Revision    : 1.0 - initial release
// ============================================================================
module ds2_input_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/ds2_pad_responder.sv
`default_nettype none
// ============================================================================
// Module      : ds2_pad_responder
// Description : Device-side DualShock2 emulation answering host transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module ds2_pad_responder
    import ds2_pkg::*;
#(
    parameter int unsigned ACK_DELAY      = 8,
    parameter int unsigned ACK_WIDTH      = 60,
    parameter logic        ANALOG_DEFAULT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ds2_att,
    input  logic        ds2_clk,
    input  logic        ds2_cmd,
    input  logic [15:0] buttons,
    input  logic [7:0]  stick_rx,
    input  logic [7:0]  stick_ry,
    input  logic [7:0]  stick_lx,
    input  logic [7:0]  stick_ly,
    output logic        ds2_dat,
    output logic        ds2_ack,
    output logic        analog_mode,
    output logic        config_mode,
    output logic        selected
);

    logic w_att_lvl, w_att_rise, w_att_fall;
    logic w_clk_lvl_unused, w_clk_rise, w_clk_fall;
    logic w_cmd_lvl, w_cmd_rise_unused, w_cmd_fall_unused;

    ds2_input_sync #(.RESET_VAL(1'b1)) u_sync_att (
        .clk(clk), .rst(rst), .i_async(ds2_att),
        .o_sync(w_att_lvl), .o_rise(w_att_rise), .o_fall(w_att_fall)
    );
    ds2_input_sync #(.RESET_VAL(1'b1)) u_sync_clk (
        .clk(clk), .rst(rst), .i_async(ds2_clk),
        .o_sync(w_clk_lvl_unused), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
    );
    ds2_input_sync #(.RESET_VAL(1'b1)) u_sync_cmd (
        .clk(clk), .rst(rst), .i_async(ds2_cmd),
        .o_sync(w_cmd_lvl), .o_rise(w_cmd_rise_unused), .o_fall(w_cmd_fall_unused)
    );

    ds2_state_e  r_state, w_state_next;
    logic [3:0]  r_byte_idx;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx;
    logic [7:0]  r_tx;
    logic [7:0]  r_cmd;
    logic        r_dat;
    logic        r_ack;
    logic        r_ack_pend;
    logic [15:0] r_ack_dly;
    logic [15:0] r_ack_wid;
    logic [15:0] r_snap_btn;
    logic [7:0]  r_snap_rx, r_snap_ry, r_snap_lx, r_snap_ly;
    logic        r_analog, r_config;
    logic        r_stage_cfg_vld, r_stage_cfg;
    logic        r_stage_ana_vld, r_stage_ana;
    logic        r_byte3_done;

    logic [7:0]  w_rx_byte, w_id, w_reply_next, w_payload_poll;
    logic [3:0]  w_idx_next, w_len, w_last, w_payload_idx;
    logic        w_engine_on, w_byte_done, w_hdr_bad, w_ack_start, w_poll_like;

    assign w_rx_byte   = {w_cmd_lvl, r_rx};
    assign w_engine_on = (r_state == ST_HDR) || (r_state == ST_PAYLOAD);
    assign w_byte_done = w_engine_on && w_clk_rise && (r_bit_cnt == 3'd7)
                         && !w_att_rise && !w_att_fall;
    assign w_hdr_bad   = (r_state == ST_HDR) && (r_byte_idx == 4'd0)
                         && (w_rx_byte != c_cmd_start);
    assign w_id        = r_config ? c_id_config : (r_analog ? c_id_analog : c_id_digital);
    // Payload length is twice the ID low nibble; the last payload byte gets no ACK.
    assign w_len       = {w_id[2:0], 1'b0};
    assign w_last      = 4'd2 + w_len;
    assign w_idx_next  = (r_byte_idx == 4'hF) ? 4'hF : r_byte_idx + 4'd1;
    assign w_ack_start = w_byte_done && !w_hdr_bad && (r_byte_idx < w_last);
    assign w_poll_like = (r_cmd == c_cmd_poll) || ((r_cmd == c_cmd_config) && !r_config);

    always_comb begin
        w_payload_idx = w_idx_next - 4'd3;
        case (w_payload_idx)
            4'd0:    w_payload_poll = r_snap_btn[7:0];
            4'd1:    w_payload_poll = r_snap_btn[15:8];
            4'd2:    w_payload_poll = r_snap_rx;
            4'd3:    w_payload_poll = r_snap_ry;
            4'd4:    w_payload_poll = r_snap_lx;
            4'd5:    w_payload_poll = r_snap_ly;
            default: w_payload_poll = c_reply_idle;
        endcase
        w_reply_next = c_reply_idle;
        if (w_idx_next == 4'd1)
            w_reply_next = w_id;
        else if (w_idx_next == 4'd2)
            w_reply_next = c_hdr_5a;
        else if ((w_idx_next >= 4'd3) && (w_idx_next <= w_last))
            w_reply_next = w_poll_like ? w_payload_poll : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Select edges take priority over any serial clock edge in the same cycle.
    always_comb begin
        w_state_next = r_state;
        if (w_att_fall)
            w_state_next = ST_HDR;
        else if (w_att_rise)
            w_state_next = ST_IDLE;
        else begin
            case (r_state)
                ST_HDR: begin
                    if (w_byte_done) begin
                        if (w_hdr_bad)
                            w_state_next = ST_IGNORE;
                        else if (r_byte_idx == 4'd2)
                            w_state_next = ST_PAYLOAD;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx      <= '0;
            r_bit_cnt       <= '0;
            r_rx            <= '0;
            r_tx            <= c_reply_idle;
            r_cmd           <= '0;
            r_dat           <= 1'b1;
            r_ack           <= 1'b1;
            r_ack_pend      <= 1'b0;
            r_ack_dly       <= '0;
            r_ack_wid       <= '0;
            r_snap_btn      <= '1;
            r_snap_rx       <= '0;
            r_snap_ry       <= '0;
            r_snap_lx       <= '0;
            r_snap_ly       <= '0;
            r_analog        <= ANALOG_DEFAULT;
            r_config        <= 1'b0;
            r_stage_cfg_vld <= 1'b0;
            r_stage_cfg     <= 1'b0;
            r_stage_ana_vld <= 1'b0;
            r_stage_ana     <= 1'b0;
            r_byte3_done    <= 1'b0;
        end else if (w_att_fall) begin
            r_snap_btn      <= ~buttons;
            r_snap_rx       <= stick_rx;
            r_snap_ry       <= stick_ry;
            r_snap_lx       <= stick_lx;
            r_snap_ly       <= stick_ly;
            r_byte_idx      <= '0;
            r_bit_cnt       <= '0;
            r_tx            <= c_reply_idle;
            r_dat           <= 1'b1;
            r_ack           <= 1'b1;
            r_ack_pend      <= 1'b0;
            r_stage_cfg_vld <= 1'b0;
            r_stage_ana_vld <= 1'b0;
            r_byte3_done    <= 1'b0;
        end else if (w_att_rise) begin
            r_dat      <= 1'b1;
            r_ack      <= 1'b1;
            r_ack_pend <= 1'b0;
            if (r_byte3_done) begin
                if (r_stage_cfg_vld) r_config <= r_stage_cfg;
                if (r_stage_ana_vld) r_analog <= r_stage_ana;
            end
            r_stage_cfg_vld <= 1'b0;
            r_stage_ana_vld <= 1'b0;
            r_byte3_done    <= 1'b0;
        end else begin
            if (r_ack_pend) begin
                if (r_ack_dly == '0) begin
                    r_ack      <= 1'b0;
                    r_ack_wid  <= 16'(ACK_WIDTH - 1);
                    r_ack_pend <= 1'b0;
                end else begin
                    r_ack_dly <= r_ack_dly - 16'd1;
                end
            end else if (!r_ack) begin
                if (r_ack_wid == '0) r_ack <= 1'b1;
                else                 r_ack_wid <= r_ack_wid - 16'd1;
            end

            if (w_engine_on) begin
                if (w_clk_fall)
                    r_dat <= r_tx[r_bit_cnt];
                if (w_clk_rise) begin
                    r_rx      <= w_rx_byte[7:1];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (w_byte_done) begin
                    r_byte_idx <= w_idx_next;
                    r_tx       <= w_reply_next;
                    r_dat      <= 1'b1;
                    if (r_byte_idx == 4'd1)
                        r_cmd <= w_rx_byte;
                    if (r_byte_idx == 4'd3) begin
                        r_byte3_done <= 1'b1;
                        if (r_cmd == c_cmd_config) begin
                            if (!r_config && (w_rx_byte == 8'h01)) begin
                                r_stage_cfg_vld <= 1'b1;
                                r_stage_cfg     <= 1'b1;
                            end else if (r_config && (w_rx_byte == 8'h00)) begin
                                r_stage_cfg_vld <= 1'b1;
                                r_stage_cfg     <= 1'b0;
                            end
                        end else if ((r_cmd == c_cmd_set_mode) && r_config) begin
                            r_stage_ana_vld <= 1'b1;
                            r_stage_ana     <= w_rx_byte[0];
                        end
                    end
                    if (w_ack_start) begin
                        r_ack_pend <= 1'b1;
                        r_ack_dly  <= 16'(ACK_DELAY + 1);
                    end
                end
            end
        end
    end

    assign ds2_dat     = r_dat;
    assign ds2_ack     = r_ack;
    assign analog_mode = r_analog;
    assign config_mode = r_config;
    assign selected    = ~w_att_lvl;

endmodule
`default_nettype wire

// File: tb/tb_ds2_pad_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ds2_pad_responder
// Description : Directed self-checking bench for ds2_pad_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ds2_pad_responder;

    localparam int ACK_DELAY = 8;
    localparam int ACK_WIDTH = 60;
    localparam int HALF      = 10;
    localparam int EXP_DLY   = ACK_DELAY + 5;

    typedef logic [7:0] bytes9_t [9];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ds2_att = 1'b1;
    logic        ds2_clk = 1'b1;
    logic        ds2_cmd = 1'b1;
    logic [15:0] buttons = 16'h0000;
    logic [7:0]  stick_rx = 8'h80, stick_ry = 8'h80, stick_lx = 8'h80, stick_ly = 8'h80;
    logic        ds2_dat, ds2_ack, analog_mode, config_mode, selected;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] rep_v [9];
    int         dly_v [9];
    int         wid_v [9];

    ds2_pad_responder #(
        .ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH), .ANALOG_DEFAULT(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .ds2_att(ds2_att), .ds2_clk(ds2_clk), .ds2_cmd(ds2_cmd),
        .buttons(buttons),
        .stick_rx(stick_rx), .stick_ry(stick_ry), .stick_lx(stick_lx), .stick_ly(stick_ly),
        .ds2_dat(ds2_dat), .ds2_ack(ds2_ack),
        .analog_mode(analog_mode), .config_mode(config_mode), .selected(selected)
    );

    always #5 clk = ~clk;

    task automatic host_bits(input logic [7:0] c, input int nbits, output logic [7:0] r);
        r = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ds2_clk = 1'b0;
            ds2_cmd = c[i];
            repeat (HALF) @(negedge clk);
            r[i] = ds2_dat;
            ds2_clk = 1'b1;
            if (i < nbits - 1) repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic host_byte(input logic [7:0] c, output logic [7:0] r, output int dly, output int wid);
        host_bits(c, 8, r);
        dly = -1;
        wid = 0;
        for (int n = 1; n <= ACK_DELAY + ACK_WIDTH + 20; n++) begin
            @(negedge clk);
            if (ds2_ack === 1'b0) begin
                if (dly < 0) dly = n;
                wid++;
            end
        end
        ds2_cmd = 1'b1;
    endtask

    task automatic att_low();
        @(negedge clk);
        ds2_att = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic att_high();
        @(negedge clk);
        ds2_att = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_xact(input bytes9_t cmds, input int n);
        att_low();
        for (int i = 0; i < n; i++) host_byte(cmds[i], rep_v[i], dly_v[i], wid_v[i]);
        att_high();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_total++; if (ds2_dat !== 1'b1) $display("FAIL reset_dat got=%b exp=1", ds2_dat); else n_pass++;
        n_total++; if (ds2_ack !== 1'b1) $display("FAIL reset_ack got=%b exp=1", ds2_ack); else n_pass++;
        n_total++; if (analog_mode !== 1'b0) $display("FAIL reset_analog got=%b exp=0", analog_mode); else n_pass++;
        n_total++; if (config_mode !== 1'b0) $display("FAIL reset_config got=%b exp=0", config_mode); else n_pass++;
        n_total++; if (selected !== 1'b0) $display("FAIL reset_selected got=%b exp=0", selected); else n_pass++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_digital_poll();
        bytes9_t cmds = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        bytes9_t exp  = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        buttons = 16'h0001;
        att_low();
        n_total++; if (selected !== 1'b1) $display("FAIL poll_selected got=%b exp=1", selected); else n_pass++;
        for (int i = 0; i < 5; i++) host_byte(cmds[i], rep_v[i], dly_v[i], wid_v[i]);
        att_high();
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (rep_v[i] !== exp[i]) $display("FAIL poll_reply[%0d] got=%h exp=%h", i, rep_v[i], exp[i]); else n_pass++;
            n_total++;
            if (dly_v[i] != ((i < 4) ? EXP_DLY : -1))
                $display("FAIL poll_ack_delay[%0d] got=%0d exp=%0d", i, dly_v[i], (i < 4) ? EXP_DLY : -1);
            else n_pass++;
            n_total++;
            if (wid_v[i] != ((i < 4) ? ACK_WIDTH : 0))
                $display("FAIL poll_ack_width[%0d] got=%0d exp=%0d", i, wid_v[i], (i < 4) ? ACK_WIDTH : 0);
            else n_pass++;
        end
    endtask

    task automatic test_config_analog();
        bytes9_t c_enter = '{8'h01, 8'h43, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        bytes9_t c_mode  = '{8'h01, 8'h44, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        bytes9_t c_exit  = '{8'h01, 8'h43, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        bytes9_t c_poll  = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        bytes9_t e_cfg   = '{8'hFF, 8'hF3, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        bytes9_t e_poll  = '{8'hFF, 8'h73, 8'h5A, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h80};
        buttons = 16'h0000;
        run_xact(c_enter, 5);
        n_total++; if (config_mode !== 1'b1) $display("FAIL enter_config got=%b exp=1", config_mode); else n_pass++;
        n_total++; if (rep_v[3] !== 8'hFF) $display("FAIL enter_payload got=%h exp=ff", rep_v[3]); else n_pass++;
        run_xact(c_mode, 9);
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (rep_v[i] !== e_cfg[i]) $display("FAIL mode_reply[%0d] got=%h exp=%h", i, rep_v[i], e_cfg[i]); else n_pass++;
        end
        n_total++; if (analog_mode !== 1'b1) $display("FAIL set_analog got=%b exp=1", analog_mode); else n_pass++;
        n_total++; if (config_mode !== 1'b1) $display("FAIL stay_config got=%b exp=1", config_mode); else n_pass++;
        run_xact(c_exit, 9);
        n_total++; if (config_mode !== 1'b0) $display("FAIL exit_config got=%b exp=0", config_mode); else n_pass++;
        n_total++; if (rep_v[5] !== 8'h00) $display("FAIL exit_payload got=%h exp=00", rep_v[5]); else n_pass++;
        run_xact(c_poll, 9);
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (rep_v[i] !== e_poll[i]) $display("FAIL analog_reply[%0d] got=%h exp=%h", i, rep_v[i], e_poll[i]); else n_pass++;
            n_total++;
            if (dly_v[i] != ((i < 8) ? EXP_DLY : -1))
                $display("FAIL analog_ack[%0d] got=%0d exp=%0d", i, dly_v[i], (i < 8) ? EXP_DLY : -1);
            else n_pass++;
        end
    endtask

    task automatic test_bad_header();
        bytes9_t c_bad  = '{8'h81, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        bytes9_t c_poll = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        bytes9_t e_poll = '{8'hFF, 8'h73, 8'h5A, 8'hFF, 8'hBF, 8'h12, 8'h34, 8'h56, 8'h78};
        buttons = 16'h4000;
        stick_rx = 8'h12; stick_ry = 8'h34; stick_lx = 8'h56; stick_ly = 8'h78;
        run_xact(c_bad, 5);
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (rep_v[i] !== 8'hFF) $display("FAIL bad_reply[%0d] got=%h exp=ff", i, rep_v[i]); else n_pass++;
            n_total++;
            if (dly_v[i] != -1) $display("FAIL bad_ack[%0d] got=%0d exp=-1", i, dly_v[i]); else n_pass++;
        end
        run_xact(c_poll, 9);
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (rep_v[i] !== e_poll[i]) $display("FAIL recover_reply[%0d] got=%h exp=%h", i, rep_v[i], e_poll[i]); else n_pass++;
        end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        int         d, w;
        bit         seen;
        // Abort while an ACK pulse is active.
        att_low();
        host_bits(8'h01, 8, r);
        seen = 1'b0;
        for (int n = 0; n < EXP_DLY + 20 && !seen; n++) begin
            @(negedge clk);
            if (ds2_ack === 1'b0) seen = 1'b1;
        end
        n_total++; if (!seen) $display("FAIL abort_ack_seen got=0 exp=1"); else n_pass++;
        ds2_att = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (ds2_ack !== 1'b1) $display("FAIL abort_ack_release got=%b exp=1", ds2_ack); else n_pass++;
        n_total++; if (selected !== 1'b0) $display("FAIL abort_selected got=%b exp=0", selected); else n_pass++;
        repeat (10) @(negedge clk);
        // Abort mid byte 3 of a config-entry transaction.
        att_low();
        host_byte(8'h01, r, d, w);
        host_byte(8'h43, r, d, w);
        host_byte(8'h00, r, d, w);
        host_bits(8'h01, 4, r);
        ds2_att = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (ds2_ack !== 1'b1) $display("FAIL abort_mid_ack got=%b exp=1", ds2_ack); else n_pass++;
        n_total++; if (ds2_dat !== 1'b1) $display("FAIL abort_mid_dat got=%b exp=1", ds2_dat); else n_pass++;
        ds2_cmd = 1'b1;
        repeat (10) @(negedge clk);
        n_total++; if (config_mode !== 1'b0) $display("FAIL abort_config got=%b exp=0", config_mode); else n_pass++;
        n_total++; if (analog_mode !== 1'b1) $display("FAIL abort_analog got=%b exp=1", analog_mode); else n_pass++;
    endtask

    task automatic test_snapshot();
        bytes9_t cmds = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        bytes9_t exp  = '{8'hFF, 8'h73, 8'h5A, 8'hEF, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
        buttons = 16'h0010;
        stick_rx = 8'h11; stick_ry = 8'h22; stick_lx = 8'h33; stick_ly = 8'h44;
        att_low();
        for (int i = 0; i < 9; i++) begin
            if (i == 2) begin
                buttons = 16'hFFFF;
                stick_rx = 8'h00; stick_ry = 8'h00; stick_lx = 8'h00; stick_ly = 8'h00;
            end
            host_byte(cmds[i], rep_v[i], dly_v[i], wid_v[i]);
        end
        att_high();
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (rep_v[i] !== exp[i]) $display("FAIL snapshot_reply[%0d] got=%h exp=%h", i, rep_v[i], exp[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_digital_poll();
        test_config_analog();
        test_bad_header();
        test_abort();
        test_snapshot();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
